ldm_dp_be: RTL
==============

// Module: ldm_dp_be
// PURPOSE
//  Parametrised true-dual-port local data memory, successor to the CGRA's basic LDM.
//  Single clock, per-byte write enables, selectable read-during-write mode, optional output register.
//  Per-port read-valid flags and a same-address collision monitor with a saturating count.
//  Sits between the CGRA PE array (port A) and the DMA/host loader (port B).
// PARAMETERS
//  AWIDTH   10  word address width; depth = 2**AWIDTH words
//  DWIDTH   32  data width; must be a multiple of 8; NBYTE = DWIDTH/8
//  WR_FIRST 0   0 = read-first (same-port read returns old word); 1 = write-first (returns merged new word)
//  OUT_REG  0   0 = read latency 1; 1 = extra output register, read latency 2
//  CWIDTH   16  width of collision counter
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst_n      in   1       synchronous reset, active low
//  a_en       in   1       port A access enable
//  a_we       in   NBYTE   port A byte write enables (bit i -> din[8i+7:8i])
//  a_addr     in   AWIDTH  port A word address
//  a_din      in   DWIDTH  port A write data
//  a_dout     out  DWIDTH  port A read data
//  a_dvalid   out  1       port A read data valid
//  b_*        --   --      port B: identical set (b_en, b_we, b_addr, b_din, b_dout, b_dvalid)
//  coll       out  1       registered pulse: same-address collision seen on previous cycle
//  coll_cnt   out  CWIDTH  saturating count of collisions since reset
// BEHAVIOUR
//  - Reset: a_dout, b_dout = 0; a_dvalid, b_dvalid = 0; coll = 0; coll_cnt = 0; output pipeline flushed.
//    Memory array is not cleared. While rst_n = 0, no writes are committed.
//  - Access: when x_en = 1 at edge N, every byte with x_we[i] = 1 is written. Bytes with x_we[i] = 0 keep their value.
//    A read always occurs, including on write cycles.
//  - Latency: x_dout/x_dvalid update at edge N+1 (OUT_REG = 0) or N+2 (OUT_REG = 1).
//    x_dvalid = 1 for exactly one cycle per accepted access.
//    x_en = 0 -> x_dvalid = 0 and x_dout holds its last value.
//  - Fully pipelined: one access per port per cycle, with no stalls or backpressure.
//  - Same-port read-during-write:
//    WR_FIRST = 0 returns the pre-write word.
//    WR_FIRST = 1 returns the merged word: new bytes where we = 1, old bytes elsewhere.
//  - Cross-port, same address, one port writes and the other only reads: the reader gets the pre-write word (both modes).
//  - Both ports write the same address:
//    bytes enabled on both ports take A's data (A wins);
//    bytes enabled on one port only take that port's data.
//    Each port's own read returns per WR_FIRST, using the final merged word in write-first mode.
//  - Collision: a_en & b_en & (a_addr == b_addr) & (|a_we | |b_we).
//    coll = 1 at edge N+1 for one cycle.
//    coll_cnt increments at N+1 and saturates at 2**CWIDTH-1, with no wrap.
//    A read/read to the same address is not a collision.
//  - Address: full AWIDTH decode; no out-of-range case exists.
//  - Reset mid-operation: in-flight reads are dropped (dvalid = 0 after reset); an access at a reset edge is not performed.
//  - Illegal parameters (DWIDTH % 8 != 0, OUT_REG > 1): elaboration-time $error.
// TESTING
//  1 Reset: hold rst_n = 0 for 3 cycles with a_en = 1, a_we = 4'hF, addr 5.
//    -> all outputs 0, no dvalid; after release, read addr 5 != written data from the reset window.
//  2 Byte enables: write 32'h11223344 to addr 3, then a_we = 4'b0101 with din 32'hAABBCCDD.
//    -> read addr 3 returns 32'h11BB33DD; dvalid one cycle after the read edge (OUT_REG = 0), two cycles after (OUT_REG = 1).
//  3 RDW modes: addr 7 holds 32'h0; write 32'hCAFEF00D to addr 7 on A.
//    -> a_dout = 32'h0 with WR_FIRST = 0, 32'hCAFEF00D with WR_FIRST = 1;
//    B reading addr 7 in the same cycle gets 32'h0 in both modes.
//  4 Write/write collision: A we = 4'b0011 din 32'h0000AAAA, B we = 4'b0110 din 32'h00BBBB00, same addr, init 0.
//    -> word = 32'h00BBAAAA; coll pulses once; coll_cnt = 1.
//  5 Saturation: CWIDTH = 4, 20 back-to-back colliding cycles.
//    -> coll_cnt stops at 15; coll high 20 cycles; a read/read same-address cycle leaves count unchanged.
//  6 Throughput and random: 1000 random cycles, both ports, mixed en/we, compared against a reference model with the byte-merge/priority rules above.
//    -> zero mismatches; dvalid count equals accepted access count per port.

Source files
------------

// File: rtl/ldm_dp_be.sv
// True-dual-port local data memory with byte enables, selectable read-during-write
// behaviour, optional output register and a same-address collision monitor.
module ldm_dp_be #(
  parameter int AWIDTH   = 10,
  parameter int DWIDTH   = 32,
  parameter int WR_FIRST = 0,
  parameter int OUT_REG  = 0,
  parameter int CWIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic [DWIDTH/8-1:0]   a_we,
  input  logic [AWIDTH-1:0]     a_addr,
  input  logic [DWIDTH-1:0]     a_din,
  output logic [DWIDTH-1:0]     a_dout,
  output logic                  a_dvalid,
  input  logic                  b_en,
  input  logic [DWIDTH/8-1:0]   b_we,
  input  logic [AWIDTH-1:0]     b_addr,
  input  logic [DWIDTH-1:0]     b_din,
  output logic [DWIDTH-1:0]     b_dout,
  output logic                  b_dvalid,
  output logic                  coll,
  output logic [CWIDTH-1:0]     coll_cnt
);

  localparam int NBYTE = DWIDTH / 8;
  localparam int DEPTH = 2 ** AWIDTH;

  if ((DWIDTH % 8) != 0 || DWIDTH < 8) begin : g_bad_dwidth
    $error("ldm_dp_be: DWIDTH (%0d) must be a non-zero multiple of 8", DWIDTH);
  end
  if (OUT_REG < 0 || OUT_REG > 1) begin : g_bad_out_reg
    $error("ldm_dp_be: OUT_REG (%0d) must be 0 or 1", OUT_REG);
  end
  if (WR_FIRST < 0 || WR_FIRST > 1) begin : g_bad_wr_first
    $error("ldm_dp_be: WR_FIRST (%0d) must be 0 or 1", WR_FIRST);
  end

  logic [DWIDTH-1:0] mem [0:DEPTH-1];

  logic [NBYTE-1:0]  a_bwe, b_bwe;
  logic              a_wr, b_wr, same_addr, both_wr, coll_now;
  logic [DWIDTH-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;

  assign a_bwe     = a_we & {NBYTE{a_en}};
  assign b_bwe     = b_we & {NBYTE{b_en}};
  assign a_wr      = |a_bwe;
  assign b_wr      = |b_bwe;
  assign same_addr = (a_addr == b_addr);
  assign both_wr   = a_wr & b_wr & same_addr;
  assign coll_now  = a_en & b_en & same_addr & ((|a_we) | (|b_we));

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  // Final word each writing port leaves at its own address; A wins shared bytes.
  always_comb begin
    a_new = a_old;
    b_new = b_old;
    for (int i = 0; i < NBYTE; i++) begin
      if (a_bwe[i])
        a_new[8*i +: 8] = a_din[8*i +: 8];
      else if (both_wr && b_bwe[i])
        a_new[8*i +: 8] = b_din[8*i +: 8];

      if (both_wr && a_bwe[i])
        b_new[8*i +: 8] = a_din[8*i +: 8];
      else if (b_bwe[i])
        b_new[8*i +: 8] = b_din[8*i +: 8];
    end
  end

  assign a_rd = ((WR_FIRST != 0) && a_wr) ? a_new : a_old;
  assign b_rd = ((WR_FIRST != 0) && b_wr) ? b_new : b_old;

  // Port A bytes are committed after port B so that A takes shared bytes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (b_bwe[i])
          mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
        if (a_bwe[i])
          mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
      end
    end
  end

  logic [DWIDTH-1:0] a_q1, b_q1;
  logic              a_v1, b_v1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q1 <= '0;
      b_q1 <= '0;
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
    end else begin
      a_v1 <= a_en;
      b_v1 <= b_en;
      if (a_en)
        a_q1 <= a_rd;
      if (b_en)
        b_q1 <= b_rd;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [DWIDTH-1:0] a_q2, b_q2;
    logic              a_v2, b_v2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q2 <= '0;
        b_q2 <= '0;
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1)
          a_q2 <= a_q1;
        if (b_v1)
          b_q2 <= b_q1;
      end
    end

    assign a_dout   = a_q2;
    assign b_dout   = b_q2;
    assign a_dvalid = a_v2;
    assign b_dvalid = b_v2;
  end else begin : g_no_out_reg
    assign a_dout   = a_q1;
    assign b_dout   = b_q1;
    assign a_dvalid = a_v1;
    assign b_dvalid = b_v1;
  end

  // Collision pulse and a counter that sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      coll <= coll_now;
      if (coll_now && (coll_cnt != {CWIDTH{1'b1}}))
        coll_cnt <= coll_cnt + 1'b1;
    end
  end

endmodule
